nx_ob_packer: RTL and testbench
===============================

NX_OB_PACKER -- requirements
Module: nx_ob_packer

Interface
REQ-001 Parameter AXI4_DATA_WIDTH, default 64, outbound beat width; only 64 is supported.
REQ-002 Parameter AXI4_STRB_WIDTH, default AXI4_DATA_WIDTH/8, keep/strobe width.
REQ-003 Parameter AXI4_ID_WIDTH, default 1, stream ID width.
REQ-004 Parameter FLUSH_CYCLES, default 16, idle cycles in HALF before a partial beat is emitted; legal range 1..255.
REQ-005 Port clk, input, 1, sole clock; all state is updated on the rising edge.
REQ-006 Port rstn, input, 1, asynchronous active-low reset.
REQ-007 Ports ctrl_data_i (input, 31, control payload), ctrl_valid_i (input, 1) and ctrl_ready_o (output, 1) SHALL form the control requester handshake.
REQ-008 Ports core_data_i (input, 31, core payload), core_valid_i (input, 1) and core_ready_o (output, 1) SHALL form the core requester handshake.
REQ-009 Port flush_i, input, 1, requests immediate emission of a held partial beat.
REQ-010 Ports outbound_tdata/tkeep/tstrb/tid/tlast/tvalid (outputs; widths 64/8/8/ID/1/1) and outbound_tready (input, 1) SHALL form the AXI4-stream master.
REQ-011 Port status_beats_o, output, 32, count of beats emitted.

Function
REQ-012 Each accepted word SHALL be formed as {source, payload[30:0]}, with source 1 for control and 0 for core.
REQ-013 Arbitration SHALL be round-robin using a last-grant register: when both requesters are valid, the one not granted last wins; when only one is valid, it wins.
REQ-014 ready is asserted only to the winner, and only when can_accept = (state != FULL) || outbound_tready; ready SHALL be combinational from valid, state and tready.
REQ-015 Transfer occurs when valid && ready; at most one word is accepted per cycle.
REQ-016 The state machine SHALL have states EMPTY, HALF and FULL.
REQ-017 EMPTY: an accepted word goes to lane [31:0] and the next state is HALF; otherwise the state stays EMPTY.
REQ-018 HALF: an accepted word goes to lane [63:32], tkeep=8'hFF, next state FULL.
REQ-019 HALF with no accept, when the idle counter reaches FLUSH_CYCLES-1 or flush_i=1, SHALL go to FULL with tkeep=8'h0F and the upper lane zero.
REQ-020 FULL: outbound_tvalid=1 and beat contents are stable until tready.
REQ-021 FULL on tready: with a simultaneous accept the word goes to the low lane and the next state is HALF; otherwise the next state is EMPTY.
REQ-022 A simultaneous accept and timeout/flush in HALF SHALL favour the accept, producing a full beat.
REQ-023 flush_i in EMPTY or FULL SHALL have no effect.
REQ-024 The idle counter (8 bit) increments each HALF cycle without accept and clears on any accept or on leaving HALF.
REQ-025 outbound_tvalid SHALL be a register output; latency from the completing accept (or flush/timeout cycle) to tvalid is 1 cycle.
REQ-026 outbound_tstrb SHALL equal outbound_tkeep, tid SHALL be 0 and tlast SHALL be 1 on every beat.
REQ-027 status_beats_o SHALL increment on each tvalid && tready and wrap from 0xFFFFFFFF to 0.
REQ-028 The last-grant register updates only on transfer.
REQ-029 Payload order within the output stream SHALL equal acceptance order: low lane first.

Reset
REQ-030 rstn low SHALL immediately force:
- state EMPTY
- idle counter 0
- last-grant = core, so control wins first contention
- outbound_tdata 0, tkeep 0, tstrb 0
- outbound_tvalid 0
- status_beats_o 0
REQ-031 Reset mid-beat SHALL discard held data without emission.
REQ-032 While rstn is low, ctrl_ready_o and core_ready_o SHALL be 0.

Structure
REQ-033 A shared package SHALL hold the state enumeration (EMPTY/HALF/FULL), the lane keep constants 8'hFF/8'h0F, and the source-bit encoding.
REQ-034 The round-robin arbiter SHALL be a sub-module nx_rr_arbiter_2 (two requests, grant, advance), reusable elsewhere.

Verification
REQ-035 Core sends 0x11 then 0x22 with tready=1: one beat, tdata=0x00000022_00000011, tkeep=FF, tvalid 1 cycle after the second accept.
REQ-036 Control and core valid together from reset with payloads 0x5 and 0x7: beat tdata=0x00000007_80000005 (control first); the next contention grants core first.
REQ-037 A single core word 0x3 then idle, FLUSH_CYCLES=4: tvalid rises 4 cycles after entering HALF, tdata=0x3, tkeep=0F.
REQ-038 HALF with flush_i asserted in the same cycle as a core accept of 0x9: full beat with upper lane 0x9, tkeep=FF, no partial beat.
REQ-039 tready held low with the beat in FULL for 10 cycles: both readies 0 and the beat stable; on tready=1 with a pending word, state goes to HALF and status_beats_o increments by 1.
REQ-040 rstn deasserted while in HALF: no beat is emitted, and the next two accepted words form a fresh beat starting in the low lane.

Source files
------------

// File: rtl/nx_ob_packer_pkg.sv
// Shared definitions for the outbound packer: FSM states,
// lane keep patterns and the source tag carried in bit 31.
package nx_ob_packer_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [7:0] KEEP_FULL = 8'hFF;
  localparam logic [7:0] KEEP_HALF = 8'h0F;

  localparam logic SRC_CTRL = 1'b1;
  localparam logic SRC_CORE = 1'b0;

  function automatic logic [31:0] mk_word(
    input logic        src,
    input logic [30:0] pl
  );
    return {src, pl};
  endfunction

endpackage

// File: rtl/nx_rr_arbiter_2.sv
// Two-way round-robin arbiter with a last-grant register;
// the register only moves when the caller signals a transfer.
module nx_rr_arbiter_2 #(
  parameter logic RST_LAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // last_q holds the index of the requester served most recently
  always_comb begin
    gnt_o = 2'b00;
    if (&req_i) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end else if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
    last_d = last_q;
    if (advance_i && (|gnt_o)) begin
      last_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= RST_LAST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/nx_ob_packer.sv
// Packs 32-bit tagged words from two requesters into 64-bit
// AXI4-stream beats, flushing a lone word on idle timeout or request.
module nx_ob_packer
  import nx_ob_packer_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8,
  parameter int AXI4_ID_WIDTH   = 1,
  parameter int FLUSH_CYCLES    = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [30:0]                ctrl_data_i,
  input  logic                       ctrl_valid_i,
  output logic                       ctrl_ready_o,
  input  logic [30:0]                core_data_i,
  input  logic                       core_valid_i,
  output logic                       core_ready_o,
  input  logic                       flush_i,
  output logic [AXI4_DATA_WIDTH-1:0] outbound_tdata,
  output logic [AXI4_STRB_WIDTH-1:0] outbound_tkeep,
  output logic [AXI4_STRB_WIDTH-1:0] outbound_tstrb,
  output logic [AXI4_ID_WIDTH-1:0]   outbound_tid,
  output logic                       outbound_tlast,
  output logic                       outbound_tvalid,
  input  logic                       outbound_tready,
  output logic [31:0]                status_beats_o
);

  localparam logic [7:0] IDLE_LIM = 8'(FLUSH_CYCLES - 1);

  logic [1:0]                 state_q, state_d;
  logic [7:0]                 idle_q, idle_d;
  logic [AXI4_DATA_WIDTH-1:0] data_q, data_d;
  logic [AXI4_STRB_WIDTH-1:0] keep_q, keep_d;
  logic                       tvalid_q, tvalid_d;
  logic [31:0]                beats_q, beats_d;

  logic [1:0]  gnt;
  logic        can_accept;
  logic        acc;
  logic        timeout;
  logic [31:0] word;

  nx_rr_arbiter_2 #(
    .RST_LAST (1'b1)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rstn),
    .req_i     ({core_valid_i, ctrl_valid_i}),
    .advance_i (acc),
    .gnt_o     (gnt)
  );

  assign can_accept   = (state_q != ST_FULL) || outbound_tready;
  assign ctrl_ready_o = rstn & can_accept & gnt[0];
  assign core_ready_o = rstn & can_accept & gnt[1];
  assign acc = (ctrl_ready_o & ctrl_valid_i)
             | (core_ready_o & core_valid_i);
  assign word = core_ready_o ? mk_word(SRC_CORE, core_data_i)
                             : mk_word(SRC_CTRL, ctrl_data_i);
  assign timeout = (idle_q == IDLE_LIM) || flush_i;

  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    data_d   = data_q;
    keep_d   = keep_q;
    tvalid_d = tvalid_q;
    beats_d  = beats_q + {31'd0, tvalid_q & outbound_tready};
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          data_d  = {32'd0, word};
          idle_d  = 8'd0;
          state_d = ST_HALF;
        end
      end
      ST_HALF: begin
        // an accept in the same cycle as a timeout wins: full beat
        if (acc) begin
          data_d[63:32] = word;
          keep_d        = KEEP_FULL;
          tvalid_d      = 1'b1;
          idle_d        = 8'd0;
          state_d       = ST_FULL;
        end else if (timeout) begin
          data_d[63:32] = 32'd0;
          keep_d        = KEEP_HALF;
          tvalid_d      = 1'b1;
          idle_d        = 8'd0;
          state_d       = ST_FULL;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      ST_FULL: begin
        if (outbound_tready) begin
          tvalid_d = 1'b0;
          idle_d   = 8'd0;
          if (acc) begin
            data_d  = {32'd0, word};
            state_d = ST_HALF;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: begin
        state_d  = ST_EMPTY;
        tvalid_d = 1'b0;
        idle_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_EMPTY;
      idle_q   <= 8'd0;
      data_q   <= '0;
      keep_q   <= '0;
      tvalid_q <= 1'b0;
      beats_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      data_q   <= data_d;
      keep_q   <= keep_d;
      tvalid_q <= tvalid_d;
      beats_q  <= beats_d;
    end
  end

  assign outbound_tdata  = data_q;
  assign outbound_tkeep  = keep_q;
  assign outbound_tstrb  = keep_q;
  assign outbound_tid    = '0;
  assign outbound_tlast  = 1'b1;
  assign outbound_tvalid = tvalid_q;
  assign status_beats_o  = beats_q;

endmodule

// File: tb/tb_nx_ob_packer.sv
// Directed vector table plus randomized run against a
// queue-based model of word packing and beat emission.
module tb_nx_ob_packer;

  localparam int FC = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [30:0] ctrl_data = '0;
  logic        ctrl_valid = 1'b0;
  logic        ctrl_ready;
  logic [30:0] core_data = '0;
  logic        core_valid = 1'b0;
  logic        core_ready;
  logic        flush = 1'b0;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [7:0]  tstrb;
  logic [0:0]  tid;
  logic        tlast;
  logic        tvalid;
  logic        tready = 1'b0;
  logic [31:0] beats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nx_ob_packer #(
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .ctrl_data_i     (ctrl_data),
    .ctrl_valid_i    (ctrl_valid),
    .ctrl_ready_o    (ctrl_ready),
    .core_data_i     (core_data),
    .core_valid_i    (core_valid),
    .core_ready_o    (core_ready),
    .flush_i         (flush),
    .outbound_tdata  (tdata),
    .outbound_tkeep  (tkeep),
    .outbound_tstrb  (tstrb),
    .outbound_tid    (tid),
    .outbound_tlast  (tlast),
    .outbound_tvalid (tvalid),
    .outbound_tready (tready),
    .status_beats_o  (beats)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        cv;
    logic [30:0] cd;
    logic        kv;
    logic [30:0] kd;
    logic        fl;
    logic        tr;
    logic        ecr;
    logic        ekr;
    logic        etv;
    logic [63:0] edata;
    logic [7:0]  ekeep;
    int          ebeats;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic cv, input logic [30:0] cd,
    input logic kv, input logic [30:0] kd,
    input logic fl, input logic tr,
    input logic ecr, input logic ekr, input logic etv,
    input logic [63:0] edata, input logic [7:0] ekeep,
    input int ebeats);
    vec_t r;
    r.cv = cv; r.cd = cd; r.kv = kv; r.kd = kd;
    r.fl = fl; r.tr = tr;
    r.ecr = ecr; r.ekr = ekr; r.etv = etv;
    r.edata = edata; r.ekeep = ekeep; r.ebeats = ebeats;
    return r;
  endfunction

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
  } beat_t;

  beat_t       out_q[$];
  logic [31:0] hold_q[$];
  int          m_idle;
  logic        m_last_core;
  logic [31:0] m_beats;

  task automatic model_reset();
    out_q.delete();
    hold_q.delete();
    m_idle = 0;
    m_last_core = 1'b1;
    m_beats = 0;
  endtask

  // compare current outputs against the model, then advance it
  task automatic model_step();
    logic busy, can, wc, ecr, ekr;
    beat_t b;
    logic [31:0] w;
    busy = (out_q.size() != 0);
    can = !busy || tready;
    wc = (ctrl_valid && core_valid) ? m_last_core : ctrl_valid;
    ecr = wc && can;
    ekr = core_valid && !wc && can;
    chk("rnd_ctrl_ready", 64'(ctrl_ready), 64'(ecr));
    chk("rnd_core_ready", 64'(core_ready), 64'(ekr));
    chk("rnd_tvalid", 64'(tvalid), 64'(busy));
    chk("rnd_beats", 64'(beats), 64'(m_beats));
    if (busy) begin
      chk("rnd_tdata", tdata, out_q[0].d);
      chk("rnd_tkeep", 64'(tkeep), 64'(out_q[0].k));
      chk("rnd_tstrb", 64'(tstrb), 64'(out_q[0].k));
      chk("rnd_tlast_tid", 64'({tlast, tid}), 64'(2'b10));
    end
    if (busy && tready) begin
      void'(out_q.pop_front());
      m_beats++;
    end
    if (ecr || ekr) begin
      w = ecr ? {1'b1, ctrl_data} : {1'b0, core_data};
      m_last_core = ekr;
      hold_q.push_back(w);
      m_idle = 0;
      if (hold_q.size() == 2) begin
        b.d = {hold_q[1], hold_q[0]};
        b.k = 8'hFF;
        out_q.push_back(b);
        hold_q.delete();
      end
    end else if (hold_q.size() == 1) begin
      if (flush || m_idle == FC - 1) begin
        b.d = {32'd0, hold_q[0]};
        b.k = 8'h0F;
        out_q.push_back(b);
        hold_q.delete();
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end
  endtask

  initial begin
    // reset state, readies held low under reset
    ctrl_valid = 1'b1;
    core_valid = 1'b1;
    tready = 1'b1;
    #12;
    chk("rst_ctrl_ready", 64'(ctrl_ready), 64'd0);
    chk("rst_core_ready", 64'(core_ready), 64'd0);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_tkeep", 64'({tkeep, tstrb}), 64'd0);
    chk("rst_beats", 64'(beats), 64'd0);
    ctrl_valid = 1'b0;
    core_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    tbl.push_back(mk(0,0,1,31'h11,0,1, 0,1,0,0,0,0));
    tbl.push_back(mk(0,0,1,31'h22,0,1, 0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,1,64'h00000022_00000011,8'hFF,0));
    tbl.push_back(mk(1,31'h5,1,31'h7,0,1, 1,0,0,0,0,1));
    tbl.push_back(mk(1,31'h6,1,31'h7,0,1, 0,1,0,0,0,1));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1,31'h6,0,0,0,0, 0,0,1,64'h00000007_80000005,8'hFF,1));
    tbl.push_back(mk(1,31'h6,0,0,0,1, 1,0,1,64'h00000007_80000005,8'hFF,1));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,2));
    tbl.push_back(mk(0,0,1,31'h9,1,1, 0,1,0,0,0,2));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,1,64'h00000009_80000006,8'hFF,2));
    tbl.push_back(mk(0,0,1,31'h3,0,1, 0,1,0,0,0,3));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,3));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,1,64'h3,8'h0F,3));
    tbl.push_back(mk(0,0,0,0,1,1, 0,0,0,0,0,4));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,4));

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      ctrl_valid = tbl[i].cv; ctrl_data = tbl[i].cd;
      core_valid = tbl[i].kv; core_data = tbl[i].kd;
      flush = tbl[i].fl; tready = tbl[i].tr;
      @(negedge clk);
      chk($sformatf("v%0d_ctrl_ready", i), 64'(ctrl_ready), 64'(tbl[i].ecr));
      chk($sformatf("v%0d_core_ready", i), 64'(core_ready), 64'(tbl[i].ekr));
      chk($sformatf("v%0d_tvalid", i), 64'(tvalid), 64'(tbl[i].etv));
      chk($sformatf("v%0d_beats", i), 64'(beats), 64'(tbl[i].ebeats));
      if (tbl[i].etv) begin
        chk($sformatf("v%0d_tdata", i), tdata, tbl[i].edata);
        chk($sformatf("v%0d_tkeep", i), 64'(tkeep), 64'(tbl[i].ekeep));
        chk($sformatf("v%0d_tstrb", i), 64'(tstrb), 64'(tbl[i].ekeep));
        chk($sformatf("v%0d_tlast_tid", i), 64'({tlast, tid}), 64'(2'b10));
      end
    end

    // reset while a lone word is held: it must vanish
    @(posedge clk); #1;
    core_valid = 1'b1; core_data = 31'hA; flush = 1'b0;
    @(negedge clk);
    chk("mid_accept", 64'(core_ready), 64'd1);
    @(posedge clk); #1;
    core_valid = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
    chk("mid_rst_tdata", tdata, 64'd0);
    chk("mid_rst_beats", 64'(beats), 64'd0);
    chk("mid_rst_ready", 64'({ctrl_ready, core_ready}), 64'd0);
    core_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 64'(tvalid), 64'd0);
    end
    @(posedge clk); #1;
    core_valid = 1'b1; core_data = 31'hB;
    @(posedge clk); #1;
    core_data = 31'hC;
    @(posedge clk); #1;
    core_valid = 1'b0;
    @(negedge clk);
    chk("fresh_tvalid", 64'(tvalid), 64'd1);
    chk("fresh_tdata", tdata, 64'h0000000C_0000000B);
    chk("fresh_tkeep", 64'(tkeep), 64'hFF);
    @(negedge clk);
    chk("fresh_beats", 64'(beats), 64'd1);

    // randomized run against the model
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      ctrl_valid = ($urandom_range(0, 9) < 3);
      core_valid = ($urandom_range(0, 9) < 3);
      ctrl_data = 31'($urandom);
      core_data = 31'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
